rsa_modexp_core: RTL

Parametrised RSA modular-exponentiation engine computing M^E mod N with two parallel radix-2 Montgomery multipliers. Successor to the fixed 256-bit/8-bit RSA core, generalised in key width and host bus width. Adds an operand error check, a done pulse, read-back of every register, and optional zero-exponent skipping. Sits behind the same byte-addressed host register port (we/oe/start/reg_sel/addr) used by the lab host/LA setup.

---
 rtl/rsa_modexp_core.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: M^E mod N with two radix-2 Montgomery lanes running in parallel
// (lane 0 squares T, lane 1 multiplies T into S). Host side is a byte-addressed
// register port; result/M/E/N all read back.
// Optional build macro: RSA_ZERO_SKIP_EN -- end MUL after the highest set bit of E.

// One Montgomery accumulator: per cycle R = (R + a_bit*B [+N]) / 2.
module rsa_mm_lane #(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             a_bit,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] n,
  output logic [NBITS+1:0] acc
);
  logic [NBITS+1:0] sum, sum_n;

  // Add the partial product, then N if odd so the halving is exact.
  always_comb begin
    sum   = acc + (a_bit ? {2'b00, b} : '0);
    sum_n = sum[0] ? sum + {2'b00, n} : sum;
  end

  // Accumulator register, cleared between multiplies.
  always_ff @(posedge clk) begin
    if (!reset || clr) acc <= '0;
    else if (en)       acc <= sum_n >> 1;
  end
endmodule

module rsa_modexp_core #(
  parameter  int NBITS = 256,
  parameter  int DW    = 8,
  localparam int WORDS = NBITS / DW,
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          oe,
  input  logic          start,
  input  logic [1:0]    reg_sel,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_i,
  output logic          ready,
  output logic [DW-1:0] data_o,
  output logic          done,
  output logic          err
);
  localparam int CW = $clog2(NBITS + 1);
  localparam int IW = $clog2(NBITS);
  localparam logic [CW-1:0] J_LAST   = CW'(NBITS);
  localparam logic [CW-1:0] PRE_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] I_LAST   = CW'(NBITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRE, S_MUL, S_FIN} state_t;

  state_t           state;
  logic [NBITS-1:0] m_reg, e_reg, n_reg, res_reg, s_reg, t_reg;
  logic [CW-1:0]    jcnt, icnt;

  logic [1:0][NBITS-1:0] lane_b;
  logic [1:0][NBITS+1:0] lane_acc;
  logic                  lane_en, lane_clr;

  logic             a_bit, e_bit, mul_last, bad_op;
  logic [NBITS:0]   pre_dbl;
  logic [NBITS-1:0] t_pre, t_red, s_red;
  logic [DW-1:0]    rd_word;

  // Final conditional subtract of a Montgomery product.
  function automatic logic [NBITS-1:0] mred(input logic [NBITS+1:0] r,
                                            input logic [NBITS-1:0] n);
    return (r >= {2'b00, n}) ? r[NBITS-1:0] - n : r[NBITS-1:0];
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      rsa_mm_lane #(.NBITS(NBITS)) u_lane (
        .clk  (clk),
        .reset(reset),
        .clr  (lane_clr),
        .en   (lane_en),
        .a_bit(a_bit),
        .b    (lane_b[g]),
        .n    (n_reg),
        .acc  (lane_acc[g])
      );
    end
  endgenerate

`ifdef RSA_ZERO_SKIP_EN
  logic [CW-1:0] e_msb;
  // Highest set exponent bit; MUL stops after that step.
  always_comb begin
    e_msb = '0;
    for (int k = 0; k < NBITS; k++)
      if (e_reg[k]) e_msb = CW'(k);
  end
  assign mul_last = (icnt == e_msb);
`else
  assign mul_last = (icnt == I_LAST);
`endif

  // Datapath steering: multiplier operand bits, lane control, PRE doubling, reductions.
  always_comb begin
    a_bit     = t_reg[jcnt[IW-1:0]];
    e_bit     = e_reg[icnt[IW-1:0]];
    lane_b[0] = t_reg;
    lane_b[1] = s_reg;
    lane_en   = (state == S_MUL) && (jcnt != J_LAST);
    lane_clr  = (state == S_LOAD) || ((state == S_MUL) && (jcnt == J_LAST));
    pre_dbl   = {t_reg, 1'b0};
    t_pre     = (pre_dbl >= {1'b0, n_reg}) ? pre_dbl[NBITS-1:0] - n_reg : pre_dbl[NBITS-1:0];
    t_red     = mred(lane_acc[0], n_reg);
    s_red     = mred(lane_acc[1], n_reg);
    bad_op    = !n_reg[0] || (n_reg < NBITS'(3)) || (m_reg >= n_reg);
  end

  // Host read mux; out-of-range words read as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < WORDS; k++)
      if (int'(addr) == k)
        case (reg_sel)
          2'b00:   rd_word = res_reg[DW*k +: DW];
          2'b01:   rd_word = m_reg[DW*k +: DW];
          2'b10:   rd_word = e_reg[DW*k +: DW];
          default: rd_word = n_reg[DW*k +: DW];
        endcase
  end

  // Registered read port, only live while idle.
  always_ff @(posedge clk) begin
    if (!reset)            data_o <= '0;
    else if (ready && oe)  data_o <= rd_word;
  end

  // Control FSM plus operand/result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      m_reg   <= '0;
      e_reg   <= '0;
      n_reg   <= '0;
      res_reg <= '0;
      s_reg   <= '0;
      t_reg   <= '0;
      jcnt    <= '0;
      icnt    <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (we) begin
            // a write wins over a same-cycle start
            for (int k = 0; k < WORDS; k++)
              if (int'(addr) == k)
                case (reg_sel)
                  2'b01:   m_reg[DW*k +: DW] <= data_i;
                  2'b10:   e_reg[DW*k +: DW] <= data_i;
                  2'b11:   n_reg[DW*k +: DW] <= data_i;
                  default: ;
                endcase
          end else if (start) begin
            if (bad_op) begin
              err <= 1'b1;
            end else begin
              err   <= 1'b0;
              ready <= 1'b0;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          t_reg <= m_reg;
          s_reg <= NBITS'(1);
          jcnt  <= '0;
          icnt  <= '0;
          state <= S_PRE;
        end
        S_PRE: begin
          // T <- 2T mod N, NBITS times: puts M into Montgomery form
          t_reg <= t_pre;
          if (jcnt == PRE_LAST) begin
            jcnt <= '0;
`ifdef RSA_ZERO_SKIP_EN
            state <= (e_reg == '0) ? S_FIN : S_MUL;
`else
            state <= S_MUL;
`endif
          end else begin
            jcnt <= jcnt + 1'b1;
          end
        end
        S_MUL: begin
          // S stays in normal form since T carries the 2^NBITS factor
          if (jcnt == J_LAST) begin
            t_reg <= t_red;
            if (e_bit) s_reg <= s_red;
            jcnt <= '0;
            icnt <= icnt + 1'b1;
            if (mul_last) state <= S_FIN;
          end else begin
            jcnt <= jcnt + 1'b1;
          end
        end
        S_FIN: begin
          res_reg <= s_reg;
          done    <= 1'b1;
          ready   <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
